// File: rtl/max_unpool_router.sv
// 2x2 max-unpool router: gathers argmax history and gradients for one pooled
// frame, then streams the 2N x 2N map in raster order. Optional err output: MAX_UNPOOL_ERR_EN.
module max_unpool_router #(
    parameter int N  = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hist_valid,
    input  logic [5:0]    hist_addr,
    input  logic [2:0]    hist,
    input  logic          grad_load,
    input  logic [DW-1:0] grad_in,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [5:0]    out_row,
    output logic [5:0]    out_col,
    output logic          busy,
    output logic          done
`ifdef MAX_UNPOOL_ERR_EN
    ,output logic         err
`endif
);
    localparam int NN   = N * N;
    localparam int IW   = (NN > 1) ? $clog2(NN) : 1;
    localparam int LAST = 2 * N - 1;

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t          state, state_nxt;
    logic [NN-1:0]   mask, mask_nxt;
    logic [6:0]      grad_cnt, cnt_nxt;
    logic [5:0]      row, col;
    logic [2:0]      hist_mem [NN];
    logic [DW-1:0]   grad_mem [NN];
    logic            hist_ok, grad_ok, last_pix;
    logic [IW-1:0]   p;
    logic [1:0]      idx;

    always_comb begin
        hist_ok  = (state == COLLECT) && hist_valid && (32'(hist_addr) < NN);
        grad_ok  = (state == COLLECT) && grad_load && (32'(grad_cnt) < NN);
        mask_nxt = mask;
        if (hist_ok) mask_nxt[hist_addr[IW-1:0]] = 1'b1;
        cnt_nxt  = grad_cnt + 7'(grad_ok);
        last_pix = (row == 6'(LAST)) && (col == 6'(LAST));
        state_nxt = state;
        case (state)
            COLLECT: if ((&mask_nxt) && (32'(cnt_nxt) == NN)) state_nxt = EMIT;
            EMIT:    if (last_pix) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= COLLECT;
            mask     <= '0;
            grad_cnt <= '0;
            row      <= '0;
            col      <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (state == COLLECT) begin
                mask     <= mask_nxt;
                grad_cnt <= cnt_nxt;
            end else if (last_pix) begin
                // frame finished: clear everything so the done cycle starts a new frame
                mask     <= '0;
                grad_cnt <= '0;
                row      <= '0;
                col      <= '0;
                done     <= 1'b1;
            end else if (col == 6'(LAST)) begin
                col <= '0;
                row <= row + 6'd1;
            end else begin
                col <= col + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hist_ok) hist_mem[hist_addr[IW-1:0]] <= hist;
        if (grad_ok) grad_mem[grad_cnt[IW-1:0]]  <= grad_in;
    end

`ifdef MAX_UNPOOL_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if ((state == COLLECT) &&
                 ((hist_valid && ((hist > 3'd3) || (32'(hist_addr) >= NN))) ||
                  (grad_load && (32'(grad_cnt) == NN))))
            err <= 1'b1;
    end
`endif

    // outputs derive only from registered state, so async reset zeroes them at once
    always_comb begin
        p         = IW'(((32'(row) >> 1) * N) + (32'(col) >> 1));
        idx       = {row[0], col[0]};
        out_valid = (state == EMIT);
        busy      = out_valid;
        out_row   = out_valid ? row : '0;
        out_col   = out_valid ? col : '0;
        out_data  = (out_valid && (hist_mem[p] == {1'b0, idx})) ? grad_mem[p] : '0;
    end
endmodule

// File: tb/tb_max_unpool_router.sv
// Randomized bench for max_unpool_router with a frame-level reference model.
module tb_max_unpool_router;
    localparam int N  = 3;
    localparam int NN = N * N;
    localparam int M  = 2 * N;

    logic        clk = 1'b0, rst = 1'b1;
    logic        hist_valid = 0, grad_load = 0;
    logic [5:0]  hist_addr = 0;
    logic [2:0]  hist = 0;
    logic [15:0] grad_in = 0;
    logic        out_valid, busy, done;
    logic [15:0] out_data;
    logic [5:0]  out_row, out_col;
`ifdef MAX_UNPOOL_ERR_EN
    logic        err;
`endif

    max_unpool_router #(.N(N), .DW(16)) dut (
        .clk(clk), .rst(rst), .hist_valid(hist_valid), .hist_addr(hist_addr),
        .hist(hist), .grad_load(grad_load), .grad_in(grad_in),
        .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .busy(busy), .done(done)
`ifdef MAX_UNPOOL_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference model: frame contents plus position in the emitted stream (-1 = collecting)
    int          emit = -1, mcnt = 0;
    bit [NN-1:0] mmask = '0;
    bit [2:0]    mh [NN];
    bit [15:0]   mg [NN];
    bit          mdone = 0, merr = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            emit = -1; mcnt = 0; mmask = '0; mdone = 0; merr = 0;
        end else begin
            mdone = 0;
            if (emit >= 0) begin
                if (emit == 4 * NN - 1) begin
                    emit = -1; mdone = 1; mmask = '0; mcnt = 0;
                end else emit++;
            end else begin
                if (hist_valid) begin
                    if (hist_addr < NN) begin
                        mh[hist_addr] = hist; mmask[hist_addr] = 1'b1;
                    end else merr = 1;
                    if (hist > 3) merr = 1;
                end
                if (grad_load) begin
                    if (mcnt < NN) begin
                        mg[mcnt] = grad_in; mcnt++;
                    end else merr = 1;
                end
                if (&mmask && mcnt == NN) emit = 0;
            end
        end
    end

    logic [15:0] cap [M][M];
    int n_out = 0, n_done = 0;

    always @(negedge clk) begin
        int er, ec, pp, pos;
        logic [15:0] ed;
        er = 0; ec = 0; ed = 0;
        if (emit >= 0) begin
            er = emit / M; ec = emit % M;
            pp = (er / 2) * N + ec / 2;
            pos = (er % 2) * 2 + (ec % 2);
            ed = (int'(mh[pp]) == pos) ? mg[pp] : 16'h0;
        end
        chk("out_valid", out_valid, emit >= 0);
        chk("busy", busy, emit >= 0);
        chk("done", done, mdone);
        chk("out_row", out_row, er);
        chk("out_col", out_col, ec);
        chk("out_data", out_data, ed);
`ifdef MAX_UNPOOL_ERR_EN
        chk("err", err, merr);
`endif
        if (out_valid) begin
            if (out_row < M && out_col < M) cap[out_row][out_col] = out_data;
            n_out++;
        end
        if (done) n_done++;
    end

    // one input cycle, starting and ending at a falling edge
    task automatic cyc(input logic hv, input logic [5:0] ha, input logic [2:0] h,
                       input logic gl, input logic [15:0] g);
        hist_valid = hv; hist_addr = ha; hist = h; grad_load = gl; grad_in = g;
        @(negedge clk);
        hist_valid = 0; grad_load = 0;
    endtask

    task automatic wait_done(input int prev);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (n_done > prev) begin ok = 1; break; end
        end
        chk("frame_timeout", ok, 1);
        @(negedge clk);
    endtask

    initial begin
        int b;
        logic [15:0] g;
        logic [2:0] h;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);

        // reset pulse while idle: outputs zero immediately
        #2 rst = 1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk) rst = 0;
        repeat (5) @(negedge clk);

        // all hist 0, grads 1..9
        b = n_done;
        for (int i = 0; i < NN; i++) cyc(1, 6'(i), 3'd0, 1, 16'(i + 1));
        wait_done(b);
        chk("t2_00", cap[0][0], 16'd1);
        chk("t2_02", cap[0][2], 16'd2);
        chk("t2_04", cap[0][4], 16'd3);
        chk("t2_20", cap[2][0], 16'd4);
        chk("t2_44", cap[4][4], 16'd9);
        chk("t2_01", cap[0][1], 16'd0);
        chk("t2_55", cap[5][5], 16'd0);

        // window 4 argmax at bottom-right
        b = n_done;
        for (int i = 0; i < NN; i++)
            cyc(1, 6'(i), (i == 4) ? 3'd3 : 3'd0, 1, (i == 4) ? 16'h00AA : 16'h0);
        wait_done(b);
        chk("t3_33", cap[3][3], 16'h00AA);
        chk("t3_22", cap[2][2], 16'h0);
        chk("t3_23", cap[2][3], 16'h0);
        chk("t3_32", cap[3][2], 16'h0);

        // grads first, last hist together with a redundant grad
        b = n_done;
        for (int i = 0; i < NN; i++) cyc(0, 0, 0, 1, 16'(i * 3 + 5));
        for (int i = 0; i < NN - 1; i++) cyc(1, 6'(i), 3'd2, 0, 0);
        #1 chk("t4_pre", out_valid, 0);
        cyc(1, 6'(NN - 1), 3'd2, 1, 16'hFFFF);
        #1 chk("t4_rise", out_valid, 1);
        wait_done(b);
        chk("t4_10", cap[1][0], 16'd5);
        chk("t4_54", cap[5][4], 16'd29);

        // out-of-range hist value at addr 2 zeroes that window
        b = n_done;
        cyc(1, 6'd2, 3'd5, 0, 0);
`ifdef MAX_UNPOOL_ERR_EN
        #1 chk("t6_err", err, 1);
`endif
        for (int i = 0; i < NN; i++) if (i != 2) cyc(1, 6'(i), 3'd0, 0, 0);
        for (int i = 0; i < NN; i++) cyc(0, 0, 0, 1, 16'(16'h10 + i));
        wait_done(b);
        chk("t6_04", cap[0][4], 0);
        chk("t6_05", cap[0][5], 0);
        chk("t6_14", cap[1][4], 0);
        chk("t6_15", cap[1][5], 0);
`ifdef MAX_UNPOOL_ERR_EN
        chk("t6_sticky", err, 1);
`endif

        // reset after 10 outputs, then a fresh frame
        b = n_out;
        for (int i = 0; i < NN; i++) cyc(1, 6'(i), 3'd1, 1, 16'd7);
        for (int i = 0; i < 100 && n_out < b + 10; i++) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_busy", busy, 0);
        @(negedge clk) rst = 0;
        @(negedge clk);
        b = n_done;
        for (int i = 0; i < NN; i++) cyc(1, 6'(i), 3'd1, 1, 16'd7);
        wait_done(b);
        chk("t5_01", cap[0][1], 16'd7);
        chk("t5_00", cap[0][0], 16'd0);
        chk("t5_45", cap[4][5], 16'd7);

        // random frames, inputs keep toggling during EMIT
        for (int f = 0; f < 6; f++) begin
            bit ok = 0;
            b = n_done;
            for (int i = 0; i < 800; i++) begin
                h = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
                g = 16'($urandom);
                cyc($urandom_range(0, 3) != 0,
                    ($urandom_range(0, 15) == 0) ? 6'($urandom_range(NN, 63)) : 6'($urandom_range(0, NN - 1)),
                    h, $urandom_range(0, 1) == 1, g);
                if (n_done > b) begin ok = 1; break; end
            end
            chk("rand_frame", ok, 1);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
